// File: rtl/toggle_pkg.sv
// toggle_pkg: shared types and defaults for the toggle_rx decoder.
// Holds the decoder state enum and the default counter width.
package toggle_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: two-flop synchronizer with synchronous active-high clear.
// q1 is the first stage, exposed so the decoder can preload its history.
module toggle_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q1,
  output logic q
);

  logic r_m;
  logic r_q;

  // two-stage capture of an asynchronous level
  always_ff @(posedge clk) begin
    if (clr) begin
      r_m <= 1'b0;
      r_q <= 1'b0;
    end else begin
      r_m <= d;
      r_q <= r_m;
    end
  end

  assign q1 = r_m;
  assign q  = r_q;

endmodule

// File: rtl/toggle_rx.sv
// toggle_rx: decodes a toggle-encoded event line into a pending-event count.
// Optional macro TOGGLE_RX_SYNC_EN adds a two-flop synchronizer on t_in.
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             t_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  output logic             lvl
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // w_s is the current sample, w_s_d the value it loads next edge
  logic w_s;
  logic w_s_d;

`ifdef TOGGLE_RX_SYNC_EN
  localparam logic INIT_LAST = 1'b1;

  toggle_sync u_sync (
    .clk (clk),
    .clr (clr),
    .d   (t_in),
    .q1  (w_s_d),
    .q   (w_s)
  );
`else
  localparam logic INIT_LAST = 1'b0;

  logic r_s;

  // single-stage sample for a same-clock source
  always_ff @(posedge clk) begin
    if (clr) r_s <= 1'b0;
    else     r_s <= t_in;
  end

  assign w_s   = r_s;
  assign w_s_d = t_in;
`endif

  state_t r_st;
  logic   r_sd;
  logic   r_init;

  // INIT preloads history with the incoming sample so the
  // first post-reset level never looks like an edge
  always_ff @(posedge clk) begin
    if (clr) begin
      r_st   <= INIT;
      r_sd   <= 1'b0;
      r_init <= 1'b0;
    end else begin
      unique case (r_st)
        INIT: begin
          r_sd <= w_s_d;
          if (r_init == INIT_LAST) r_st <= RUN;
          else                     r_init <= r_init + 1'b1;
        end
        RUN: begin
          r_sd <= w_s;
        end
      endcase
    end
  end

  logic w_evt;
  logic w_acc;
  logic w_full;
  logic w_ovf_set;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic r_valid;
  logic r_ovf;

  assign w_evt  = (r_st == RUN) & (w_s ^ r_sd);
  assign w_acc  = r_valid & evt_ready;
  assign w_full = (r_cnt == MAX);
  assign w_ovf_set = w_evt & ~w_acc & w_full;

  // next pending count: saturates at MAX, event+accept cancel
  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      (w_evt & ~w_acc & ~w_full): w_cnt_nxt = r_cnt + 1'b1;
      (~w_evt & w_acc):           w_cnt_nxt = r_cnt - 1'b1;
      default:                    w_cnt_nxt = r_cnt;
    endcase
  end

  // registered count and valid; valid never sees evt_ready
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= |w_cnt_nxt;
    end
  end

  // sticky overflow; a new overflow beats ovf_clr
  always_ff @(posedge clk) begin
    if (clr)            r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (ovf_clr)   r_ovf <= 1'b0;
  end

  assign evt_valid = r_valid;
  assign pend_cnt  = r_cnt;
  assign ovf       = r_ovf;
  assign lvl       = w_s;

endmodule
